// File: rtl/mips_pkg.sv
// Shared types and encodings for the multi-cycle MIPS controller: ALU codes,
// FSM states, instruction classes, opcode/funct fields and select encodings.
package mips_pkg;

   typedef enum logic [3:0] {
      ALU_AND    = 4'b0000,
      ALU_OR     = 4'b0001,
      ALU_ADD    = 4'b0010,
      ALU_XOR    = 4'b0011,
      ALU_SLL    = 4'b0100,
      ALU_SRL    = 4'b0101,
      ALU_SUB    = 4'b0110,
      ALU_SLT    = 4'b0111,
      ALU_SRA    = 4'b1000,
      ALU_SLTU   = 4'b1001,
      ALU_EQ     = 4'b1010,
      ALU_APLUS8 = 4'b1011,
      ALU_LTZ    = 4'b1100,
      ALU_PASSA  = 4'b1110
   } alu_op_t;

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM_RD, S_MEM_WR, S_WB, S_HALT
   } state_t;

   typedef enum logic [2:0] {
      CLS_NOP, CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JUMP, CLS_LINK
   } cls_t;

   localparam logic [5:0] OP_RTYPE = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02,
                          OP_JAL   = 6'h03, OP_BEQ    = 6'h04, OP_BNE   = 6'h05,
                          OP_ADDIU = 6'h09, OP_SLTI   = 6'h0A, OP_SLTIU = 6'h0B,
                          OP_ANDI  = 6'h0C, OP_ORI    = 6'h0D, OP_XORI  = 6'h0E,
                          OP_LUI   = 6'h0F, OP_LW     = 6'h23, OP_SW    = 6'h2B;

   localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA  = 6'h03,
                          F_SLLV = 6'h04, F_SRLV = 6'h06, F_SRAV = 6'h07,
                          F_JR   = 6'h08, F_JALR = 6'h09, F_ADDU = 6'h21,
                          F_SUBU = 6'h23, F_AND  = 6'h24, F_OR   = 6'h25,
                          F_XOR  = 6'h26, F_SLT  = 6'h2A, F_SLTU = 6'h2B;

   localparam logic [4:0] RT_BLTZ = 5'd0, RT_BGEZ = 5'd1;

   localparam logic [1:0] SRCA_RS = 2'd0, SRCA_PC = 2'd1, SRCA_SHAMT = 2'd2, SRCA_C16 = 2'd3;
   localparam logic [1:0] SRCB_RT = 2'd0, SRCB_SEXT = 2'd1, SRCB_ZEXT = 2'd2, SRCB_C4 = 2'd3;
   localparam logic [1:0] DST_RT = 2'd0, DST_RD = 2'd1, DST_R31 = 2'd2;
   localparam logic [1:0] PCSRC_SEQ = 2'd0, PCSRC_BR = 2'd1, PCSRC_JUMP = 2'd2, PCSRC_RS = 2'd3;

   typedef struct packed {
      cls_t       cls;
      alu_op_t    alu_op;
      logic [1:0] src_a;
      logic [1:0] src_b;
      logic [1:0] reg_dst;
      logic [1:0] pc_src;
      logic       br_on_one;
   } dec_t;

endpackage

// File: rtl/mips_instr_decode.sv
// Combinational instruction decoder: classifies the instruction and picks the
// ALU code, operand selects, destination register and branch polarity.
module mips_instr_decode
   import mips_pkg::*;
(
   input  logic [31:0] instr_i,
   output dec_t        dec_o
);

   logic [5:0] opcode;
   logic [5:0] funct;
   logic [4:0] rt;
   logic       unused_fields;

   assign opcode        = instr_i[31:26];
   assign rt            = instr_i[20:16];
   assign funct         = instr_i[5:0];
   assign unused_fields = ^{instr_i[25:21], instr_i[15:6]};

   always_comb begin
      dec_o.cls       = CLS_NOP;
      dec_o.alu_op    = ALU_ADD;
      dec_o.src_a     = SRCA_RS;
      dec_o.src_b     = SRCB_RT;
      dec_o.reg_dst   = DST_RT;
      dec_o.pc_src    = PCSRC_SEQ;
      dec_o.br_on_one = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            dec_o.cls     = CLS_ALU;
            dec_o.reg_dst = DST_RD;
            case (funct)
               F_ADDU: dec_o.alu_op = ALU_ADD;
               F_SUBU: dec_o.alu_op = ALU_SUB;
               F_AND:  dec_o.alu_op = ALU_AND;
               F_OR:   dec_o.alu_op = ALU_OR;
               F_XOR:  dec_o.alu_op = ALU_XOR;
               F_SLT:  dec_o.alu_op = ALU_SLT;
               F_SLTU: dec_o.alu_op = ALU_SLTU;
               // Shifts operate on rt (SrcB) by shamt or rs (SrcA).
               F_SLL:  begin dec_o.alu_op = ALU_SLL; dec_o.src_a = SRCA_SHAMT; end
               F_SRL:  begin dec_o.alu_op = ALU_SRL; dec_o.src_a = SRCA_SHAMT; end
               F_SRA:  begin dec_o.alu_op = ALU_SRA; dec_o.src_a = SRCA_SHAMT; end
               F_SLLV: dec_o.alu_op = ALU_SLL;
               F_SRLV: dec_o.alu_op = ALU_SRL;
               F_SRAV: dec_o.alu_op = ALU_SRA;
               F_JR:   begin dec_o.cls = CLS_JUMP; dec_o.pc_src = PCSRC_RS; end
               F_JALR: begin
                  dec_o.cls    = CLS_LINK;
                  dec_o.alu_op = ALU_APLUS8;
                  dec_o.src_a  = SRCA_PC;
                  dec_o.pc_src = PCSRC_RS;
               end
               default: dec_o.cls = CLS_NOP;
            endcase
         end
         OP_ADDIU: begin dec_o.cls = CLS_ALU; dec_o.alu_op = ALU_ADD;  dec_o.src_b = SRCB_SEXT; end
         OP_SLTI:  begin dec_o.cls = CLS_ALU; dec_o.alu_op = ALU_SLT;  dec_o.src_b = SRCB_SEXT; end
         OP_SLTIU: begin dec_o.cls = CLS_ALU; dec_o.alu_op = ALU_SLTU; dec_o.src_b = SRCB_SEXT; end
         OP_ANDI:  begin dec_o.cls = CLS_ALU; dec_o.alu_op = ALU_AND;  dec_o.src_b = SRCB_ZEXT; end
         OP_ORI:   begin dec_o.cls = CLS_ALU; dec_o.alu_op = ALU_OR;   dec_o.src_b = SRCB_ZEXT; end
         OP_XORI:  begin dec_o.cls = CLS_ALU; dec_o.alu_op = ALU_XOR;  dec_o.src_b = SRCB_ZEXT; end
         OP_LUI: begin
            dec_o.cls    = CLS_ALU;
            dec_o.alu_op = ALU_SLL;
            dec_o.src_a  = SRCA_C16;
            dec_o.src_b  = SRCB_ZEXT;
         end
         OP_LW: begin dec_o.cls = CLS_LOAD;  dec_o.src_b = SRCB_SEXT; end
         OP_SW: begin dec_o.cls = CLS_STORE; dec_o.src_b = SRCB_SEXT; end
         OP_BEQ: begin dec_o.cls = CLS_BRANCH; dec_o.alu_op = ALU_EQ; dec_o.br_on_one = 1'b1; end
         OP_BNE: begin dec_o.cls = CLS_BRANCH; dec_o.alu_op = ALU_EQ; end
         OP_REGIMM: begin
            dec_o.alu_op    = ALU_LTZ;
            dec_o.br_on_one = (rt == RT_BLTZ);
            if (rt == RT_BLTZ || rt == RT_BGEZ) dec_o.cls = CLS_BRANCH;
         end
         OP_J: begin dec_o.cls = CLS_JUMP; dec_o.pc_src = PCSRC_JUMP; end
         OP_JAL: begin
            dec_o.cls     = CLS_LINK;
            dec_o.alu_op  = ALU_APLUS8;
            dec_o.src_a   = SRCA_PC;
            dec_o.reg_dst = DST_R31;
            dec_o.pc_src  = PCSRC_JUMP;
         end
         default: dec_o.cls = CLS_NOP;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB over a wait-request memory,
// driving ALU control and datapath selects; halts when fetching from PC 0.
module mips_multicycle_control
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr,
   input  logic        mem_waitrequest,
   input  logic        alu_lsb,
   input  logic        pc_is_zero,
   output logic [3:0]  alu_control,
   output logic [1:0]  src_a_sel,
   output logic [1:0]  src_b_sel,
   output logic [1:0]  reg_dst_sel,
   output logic        reg_write,
   output logic        mem_read,
   output logic        mem_write,
   output logic        mem_addr_sel,
   output logic        ir_write,
   output logic        pc_write,
   output logic [1:0]  pc_src_sel,
   output logic        active
);

   if (RESET_VECTOR[1:0] != 2'b00) begin : g_bad_reset_vector
      $error("RESET_VECTOR must be word aligned");
   end

   state_t state_q, state_d;
   dec_t   dec_q, dec_d, dec_new;
   logic   taken;

   mips_instr_decode u_decode (
      .instr_i (instr),
      .dec_o   (dec_new)
   );

   // The decode is captured with the instruction, since instr is only valid during FETCH.
   always_comb begin
      state_d = state_q;
      dec_d   = dec_q;
      case (state_q)
         S_FETCH: begin
            if (pc_is_zero) begin
               state_d = S_HALT;
            end else if (!mem_waitrequest) begin
               state_d = S_DECODE;
               dec_d   = dec_new;
            end
         end
         S_DECODE: state_d = S_EXEC;
         S_EXEC: begin
            case (dec_q.cls)
               CLS_ALU, CLS_LINK: state_d = S_WB;
               CLS_LOAD:          state_d = S_MEM_RD;
               CLS_STORE:         state_d = S_MEM_WR;
               default:           state_d = S_FETCH;
            endcase
         end
         S_MEM_RD: if (!mem_waitrequest) state_d = S_WB;
         S_MEM_WR: if (!mem_waitrequest) state_d = S_FETCH;
         S_WB:     state_d = S_FETCH;
         default:  state_d = S_HALT;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_FETCH;
         dec_q   <= '0;
      end else begin
         state_q <= state_d;
         dec_q   <= dec_d;
      end
   end

   assign taken = dec_q.br_on_one ? alu_lsb : ~alu_lsb;

   // Strobes depend on waitrequest/alu_lsb in the same cycle and are killed by reset directly.
   always_comb begin
      alu_control  = ALU_ADD;
      src_a_sel    = SRCA_RS;
      src_b_sel    = SRCB_RT;
      reg_dst_sel  = DST_RT;
      reg_write    = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      mem_addr_sel = 1'b0;
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      pc_src_sel   = PCSRC_SEQ;
      active       = 1'b1;
      case (state_q)
         S_FETCH: begin
            if (!pc_is_zero) begin
               mem_read = 1'b1;
               ir_write = ~mem_waitrequest;
            end
         end
         S_DECODE: begin
            src_a_sel = SRCA_PC;
            src_b_sel = SRCB_C4;
         end
         S_EXEC: begin
            alu_control = dec_q.alu_op;
            src_a_sel   = dec_q.src_a;
            src_b_sel   = dec_q.src_b;
            case (dec_q.cls)
               CLS_BRANCH: begin
                  pc_write   = 1'b1;
                  pc_src_sel = taken ? PCSRC_BR : PCSRC_SEQ;
               end
               CLS_JUMP, CLS_LINK: begin
                  pc_write   = 1'b1;
                  pc_src_sel = dec_q.pc_src;
               end
               CLS_NOP: pc_write = 1'b1;
               default: pc_write = 1'b0;
            endcase
         end
         S_MEM_RD: begin
            mem_addr_sel = 1'b1;
            mem_read     = 1'b1;
         end
         S_MEM_WR: begin
            mem_addr_sel = 1'b1;
            mem_write    = 1'b1;
            pc_write     = ~mem_waitrequest;
         end
         S_WB: begin
            reg_write   = 1'b1;
            reg_dst_sel = dec_q.reg_dst;
            pc_write    = (dec_q.cls != CLS_LINK);
         end
         default: active = 1'b0;
      endcase
      if (reset) begin
         reg_write = 1'b0;
         mem_read  = 1'b0;
         mem_write = 1'b0;
         ir_write  = 1'b0;
         pc_write  = 1'b0;
      end
   end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: per-cycle expected control
// vectors go into a queue and a negedge monitor compares them under a mask.
module tb_mips_multicycle_control;

   localparam int W = 19;
   localparam logic [31:0] GARB = 32'hDEADBEEF;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] instr = 32'h0;
   logic        mem_waitrequest = 1'b0;
   logic        alu_lsb = 1'b0;
   logic        pc_is_zero = 1'b0;
   logic [3:0]  alu_control;
   logic [1:0]  src_a_sel, src_b_sel, reg_dst_sel, pc_src_sel;
   logic        reg_write, mem_read, mem_write, mem_addr_sel, ir_write, pc_write, active;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] msk_q[$];
   string        name_q[$];
   int           n_cmp = 0;
   int           n_bad = 0;

   mips_multicycle_control dut (
      .clk             (clk),
      .reset           (reset),
      .instr           (instr),
      .mem_waitrequest (mem_waitrequest),
      .alu_lsb         (alu_lsb),
      .pc_is_zero      (pc_is_zero),
      .alu_control     (alu_control),
      .src_a_sel       (src_a_sel),
      .src_b_sel       (src_b_sel),
      .reg_dst_sel     (reg_dst_sel),
      .reg_write       (reg_write),
      .mem_read        (mem_read),
      .mem_write       (mem_write),
      .mem_addr_sel    (mem_addr_sel),
      .ir_write        (ir_write),
      .pc_write        (pc_write),
      .pc_src_sel      (pc_src_sel),
      .active          (active)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // Packed view: alu, a, b, dst, rw, mr, mw, mas, irw, pcw, pcs, act
   function automatic logic [W-1:0] mk(input logic [3:0] alu, input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] dst, input logic rw, input logic mr, input logic mw,
                                       input logic mas, input logic irw, input logic pcw,
                                       input logic [1:0] pcs, input logic act);
      return {alu, a, b, dst, rw, mr, mw, mas, irw, pcw, pcs, act};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic cyc(input string name, input logic rst, input logic [31:0] ins, input logic wr,
                      input logic lsb, input logic pz, input logic [W-1:0] ev, input logic [W-1:0] em);
      reset           = rst;
      instr           = ins;
      mem_waitrequest = wr;
      alu_lsb         = lsb;
      pc_is_zero      = pz;
      exp_q.push_back(ev & em);
      msk_q.push_back(em);
      name_q.push_back(name);
      @(posedge clk);
      #1;
   endtask

   task automatic t_reset(input string name, input logic wr);
      cyc(name, 1'b1, GARB, wr, 1'b0, 1'b0,
          mk(4'h2, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1), '1);
   endtask

   task automatic t_fetch(input string name, input logic [31:0] ins, input logic wr);
      cyc(name, 1'b0, ins, wr, 1'b0, 1'b0,
          mk(4'h0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, !wr, 1'b0, 2'd0, 1'b1),
          mk(4'h0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1));
   endtask

   task automatic t_decode(input string name);
      cyc(name, 1'b0, GARB, 1'b0, 1'b0, 1'b0,
          mk(4'h2, 2'd1, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1),
          mk(4'hF, 2'd3, 2'd3, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1));
   endtask

   task automatic t_exec(input string name, input logic lsb, input logic [3:0] alu, input logic [1:0] a,
                         input logic [1:0] b, input logic chk_alu, input logic chk_b,
                         input logic pcw, input logic [1:0] pcs);
      cyc(name, 1'b0, GARB, 1'b0, lsb, 1'b0,
          mk(alu, a, b, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, pcw, pcs, 1'b1),
          mk(chk_alu ? 4'hF : 4'h0, chk_alu ? 2'd3 : 2'd0, chk_b ? 2'd3 : 2'd0, 2'd0,
             1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, pcw ? 2'd3 : 2'd0, 1'b1));
   endtask

   task automatic t_memrd(input string name, input logic wr);
      cyc(name, 1'b0, GARB, wr, 1'b0, 1'b0,
          mk(4'h0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1),
          mk(4'h0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1));
   endtask

   task automatic t_memwr(input string name, input logic wr);
      cyc(name, 1'b0, GARB, wr, 1'b0, 1'b0,
          mk(4'h0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, !wr, 2'd0, 1'b1),
          mk(4'h0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, wr ? 2'd0 : 2'd3, 1'b1));
   endtask

   task automatic t_wb(input string name, input logic [1:0] dst, input logic pcw);
      cyc(name, 1'b0, GARB, 1'b0, 1'b0, 1'b0,
          mk(4'h0, 2'd0, 2'd0, dst, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, pcw, 2'd0, 1'b1),
          mk(4'h0, 2'd0, 2'd0, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, pcw ? 2'd3 : 2'd0, 1'b1));
   endtask

   task automatic t_halt(input string name, input logic pz, input logic act);
      cyc(name, 1'b0, GARB, 1'b0, 1'b0, pz,
          mk(4'h0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, act),
          mk(4'h0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1));
   endtask

   // ---------------- scoreboard / monitor ----------------
   initial begin : monitor
      logic [W-1:0] e, m, got;
      string        nm;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            m   = msk_q.pop_front();
            nm  = name_q.pop_front();
            got = {alu_control, src_a_sel, src_b_sel, reg_dst_sel, reg_write, mem_read, mem_write,
                   mem_addr_sel, ir_write, pc_write, pc_src_sel, active};
            n_cmp++;
            if ((got & m) !== e) begin
               n_bad++;
               $display("FAIL %s: got %05h required %05h (mask %05h)", nm, got & m, e, m);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin : stimulus
      @(posedge clk);
      #1;
      t_reset("rst0", 1'b0);
      t_reset("rst1", 1'b0);

      // ADDU $3,$1,$2
      t_fetch("addu_f", 32'h00221821, 1'b0);
      t_decode("addu_d");
      t_exec("addu_x", 1'b0, 4'h2, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 2'd0);
      t_wb("addu_wb", 2'd1, 1'b1);

      // SUBU $5,$1,$2 after a two-cycle fetch stall with garbage on the bus
      t_fetch("subu_f0", 32'hFFFFFFFF, 1'b1);
      t_fetch("subu_f1", 32'hFFFFFFFF, 1'b1);
      t_fetch("subu_f2", 32'h00222823, 1'b0);
      t_decode("subu_d");
      t_exec("subu_x", 1'b0, 4'h6, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 2'd0);
      t_wb("subu_wb", 2'd1, 1'b1);

      // LW $4,8($1) with a 3-cycle MEM_RD stall: 8 cycles total
      t_fetch("lw_f", 32'h8C240008, 1'b0);
      t_decode("lw_d");
      t_exec("lw_x", 1'b0, 4'h2, 2'd0, 2'd1, 1'b1, 1'b1, 1'b0, 2'd0);
      for (int i = 0; i < 3; i++) t_memrd("lw_mrd_stall", 1'b1);
      t_memrd("lw_mrd_done", 1'b0);
      t_wb("lw_wb", 2'd0, 1'b1);

      // Branches: BNE not taken / taken, BEQ taken, BGEZ taken, BLTZ not taken
      t_fetch("bne1_f", 32'h14220004, 1'b0);
      t_decode("bne1_d");
      t_exec("bne_lsb1_x", 1'b1, 4'hA, 2'd0, 2'd0, 1'b1, 1'b1, 1'b1, 2'd0);
      t_fetch("bne0_f", 32'h14220004, 1'b0);
      t_decode("bne0_d");
      t_exec("bne_lsb0_x", 1'b0, 4'hA, 2'd0, 2'd0, 1'b1, 1'b1, 1'b1, 2'd1);
      t_fetch("beq_f", 32'h10220004, 1'b0);
      t_decode("beq_d");
      t_exec("beq_lsb1_x", 1'b1, 4'hA, 2'd0, 2'd0, 1'b1, 1'b1, 1'b1, 2'd1);
      t_fetch("bgez_f", 32'h04210004, 1'b0);
      t_decode("bgez_d");
      t_exec("bgez_lsb0_x", 1'b0, 4'hC, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 2'd1);
      t_fetch("bltz_f", 32'h04200004, 1'b0);
      t_decode("bltz_d");
      t_exec("bltz_lsb0_x", 1'b0, 4'hC, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 2'd0);

      // Shifts and immediates
      t_fetch("sll_f", 32'h00011100, 1'b0);
      t_decode("sll_d");
      t_exec("sll_x", 1'b0, 4'h4, 2'd2, 2'd0, 1'b1, 1'b1, 1'b0, 2'd0);
      t_wb("sll_wb", 2'd1, 1'b1);
      t_fetch("srav_f", 32'h00221807, 1'b0);
      t_decode("srav_d");
      t_exec("srav_x", 1'b0, 4'h8, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 2'd0);
      t_wb("srav_wb", 2'd1, 1'b1);
      t_fetch("lui_f", 32'h3C011234, 1'b0);
      t_decode("lui_d");
      t_exec("lui_x", 1'b0, 4'h4, 2'd3, 2'd2, 1'b1, 1'b1, 1'b0, 2'd0);
      t_wb("lui_wb", 2'd0, 1'b1);
      t_fetch("ori_f", 32'h342100FF, 1'b0);
      t_decode("ori_d");
      t_exec("ori_x", 1'b0, 4'h1, 2'd0, 2'd2, 1'b1, 1'b1, 1'b0, 2'd0);
      t_wb("ori_wb", 2'd0, 1'b1);
      t_fetch("slti_f", 32'h2822FFFF, 1'b0);
      t_decode("slti_d");
      t_exec("slti_x", 1'b0, 4'h7, 2'd0, 2'd1, 1'b1, 1'b1, 1'b0, 2'd0);
      t_wb("slti_wb", 2'd0, 1'b1);

      // SW $4,0($1) with one MEM_WR stall cycle
      t_fetch("sw_f", 32'hAC240000, 1'b0);
      t_decode("sw_d");
      t_exec("sw_x", 1'b0, 4'h2, 2'd0, 2'd1, 1'b1, 1'b1, 1'b0, 2'd0);
      t_memwr("sw_mwr_stall", 1'b1);
      t_memwr("sw_mwr_done", 1'b0);

      // JAL, then an unknown opcode
      t_fetch("jal_f", 32'h0C000100, 1'b0);
      t_decode("jal_d");
      t_exec("jal_x", 1'b0, 4'hB, 2'd1, 2'd0, 1'b1, 1'b0, 1'b1, 2'd2);
      t_wb("jal_wb", 2'd2, 1'b0);
      t_fetch("unk_f", 32'hFC000000, 1'b0);
      t_decode("unk_d");
      t_exec("unk_x", 1'b0, 4'h0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0);

      // Reset rises mid-cycle during a stalled MEM_WR
      t_fetch("sw2_f", 32'hAC240000, 1'b0);
      t_decode("sw2_d");
      t_exec("sw2_x", 1'b0, 4'h2, 2'd0, 2'd1, 1'b1, 1'b1, 1'b0, 2'd0);
      t_memwr("sw2_mwr_stall", 1'b1);
      t_reset("rst_in_mwr", 1'b1);
      t_reset("rst_hold", 1'b1);
      t_fetch("post_rst_f", GARB, 1'b1);

      // JR to a zero register: the next FETCH halts without reading
      t_fetch("jr_f", 32'h00A00008, 1'b0);
      t_decode("jr_d");
      t_exec("jr_x", 1'b0, 4'h0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd3);
      t_halt("halt_fetch", 1'b1, 1'b1);
      t_halt("halt0", 1'b1, 1'b0);
      t_halt("halt1", 1'b0, 1'b0);
      t_halt("halt2", 1'b0, 1'b0);

      repeat (4) @(negedge clk);
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: %0d expected vectors left, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
